result_capture_fifo: RTL and testbench
======================================

// Module: result_capture_fifo
// PURPOSE
//   Downstream capture stage for the top-level increment datapath. Samples the
//   {small, quad, wide} result triple on a strobe and buffers it in a DEPTH-entry
//   first-word-fall-through FIFO. The simulation harness drains it through a
//   valid/ready port. Also keeps a drop counter and a running checksum of the
//   wide lane, so the harness can check results without reading every word.
// PARAMETERS
//   DEPTH    4    FIFO entries; power of two, >= 2
//   SMALL_W  2    width of small lane
//   QUAD_W   40   width of quad lane
//   WIDE_W   70   width of wide lane and checksum
//   CNT_W    16   width of overflow counter
// PORTS
//   clk           input   1                   sole clock, rising edge
//   reset         input   1                   synchronous, active-high
//   in_valid      input   1                   capture strobe for in_* this cycle
//   in_small      input   SMALL_W             small result lane
//   in_quad       input   QUAD_W              quad result lane
//   in_wide       input   WIDE_W              wide result lane
//   out_valid     output  1                   head entry present
//   out_ready     input   1                   consumer accepts head entry
//   out_small     output  SMALL_W             head small lane
//   out_quad      output  QUAD_W              head quad lane
//   out_wide      output  WIDE_W              head wide lane
//   level         output  $clog2(DEPTH)+1     entries held, 0..DEPTH
//   overflow_cnt  output  CNT_W               dropped captures, saturating
//   checksum      output  WIDE_W              sum of accepted in_wide, mod 2^WIDE_W
// BEHAVIOUR
//   - Reset: sampled at clk edge only. On the edge with reset=1:
//     - level, overflow_cnt and checksum become 0; out_valid becomes 0.
//     - Both pointers clear. Stored contents are don't-care.
//     - in_valid and out_ready are ignored that cycle.
//   - Reset mid-operation discards all entries. No partial pop completes.
//   - Registered outputs: all outputs are registered or decoded from registered state.
//     There is no combinational path from in_* or out_ready to any output.
//   - Data outputs:
//     - out_small/out_quad/out_wide = head entry when out_valid=1, else all zero.
//   - Pop: pop = out_valid & out_ready. The head advances at the edge.
//   - Push: push = in_valid & (level<DEPTH | pop).
//     - A full FIFO accepts a capture in the same cycle it pops.
//   - Latency: a push into an empty FIFO is visible on out_valid/out_* at the next
//     edge (1 cycle). There is no same-cycle bypass.
//   - Level update: push&~pop -> +1; pop&~push -> -1; both or neither -> unchanged.
//   - Ordering: strict FIFO. Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
//   - Drop: in_valid & level==DEPTH & ~pop drops the triple.
//     - overflow_cnt increments and saturates at all-ones; it never wraps.
//     - Contents, level and checksum are unchanged by a drop.
//   - Checksum: on each accepted push, checksum <= checksum + in_wide, truncated to
//     WIDE_W bits (wraps). Drops and pops do not change it.
//   - Handshake: out_* and out_valid stay stable while out_valid=1 & out_ready=0.
// TESTING
//   1. Reset, push small=2'b11 quad=40'h1 wide=70'h5 -> next cycle out_valid=1,
//      out_*=3/1/5, level=1, checksum=70'h5.
//   2. out_ready=0, push 5 distinct triples (DEPTH=4) -> level=4, overflow_cnt=1,
//      checksum = sum of the first 4 wide values only; drain returns the first 4 in order.
//   3. Full FIFO, in_valid=1 & out_ready=1 in the same cycle -> pop and push both occur,
//      level stays 4, new triple drains last.
//   4. out_ready=1, push 10 consecutive triples -> exactly 10 pops, in order, each one
//      cycle after its push; pointers wrap twice; level never exceeds 1.
//   5. Push wide=all-ones twice -> checksum = 70'h3F_FFFF_FFFF_FFFF_FFFE.
//      With CNT_W=2, 5 drops -> overflow_cnt holds at 2'b11.
//   6. level=3, overflow_cnt=2, reset=1 for one cycle with in_valid=1 -> next cycle
//      level=0, out_valid=0, out_*=0, overflow_cnt=0, checksum=0.

Source files
------------

// File: rtl/result_capture_fifo.sv
// result_capture_fifo
//   Capture stage for the increment datapath result triple {small, quad, wide}.
//   A strobe on in_valid writes the triple into a DEPTH-entry first-word-fall-
//   through FIFO that the harness drains via a valid/ready port. A saturating
//   drop counter and a running checksum of accepted wide values are kept too.
//
// Ports
//   clk           in   sole clock, rising edge
//   reset         in   synchronous, active-high
//   in_valid      in   capture strobe for in_* this cycle
//   in_small      in   [SMALL_W] small result lane
//   in_quad       in   [QUAD_W]  quad result lane
//   in_wide       in   [WIDE_W]  wide result lane
//   out_valid     out  head entry present
//   out_ready     in   consumer accepts head entry
//   out_small     out  [SMALL_W] head small lane (zero when empty)
//   out_quad      out  [QUAD_W]  head quad lane  (zero when empty)
//   out_wide      out  [WIDE_W]  head wide lane  (zero when empty)
//   level         out  [$clog2(DEPTH)+1] entries held, 0..DEPTH
//   overflow_cnt  out  [CNT_W]   dropped captures, saturating
//   checksum      out  [WIDE_W]  sum of accepted in_wide, wrapping

module result_capture_fifo #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned SMALL_W = 2,
  parameter int unsigned QUAD_W  = 40,
  parameter int unsigned WIDE_W  = 70,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [SMALL_W-1:0]         in_small,
  input  logic [QUAD_W-1:0]          in_quad,
  input  logic [WIDE_W-1:0]          in_wide,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SMALL_W-1:0]         out_small,
  output logic [QUAD_W-1:0]          out_quad,
  output logic [WIDE_W-1:0]          out_wide,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           overflow_cnt,
  output logic [WIDE_W-1:0]          checksum
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [SMALL_W-1:0] mem_small_q [DEPTH];
  logic [QUAD_W-1:0]  mem_quad_q  [DEPTH];
  logic [WIDE_W-1:0]  mem_wide_q  [DEPTH];

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q,  level_d;
  logic [CNT_W-1:0]   ovf_q,    ovf_d;
  logic [WIDE_W-1:0]  csum_q,   csum_d;

  logic full, empty, pop, push, drop;

  always_comb begin
    full  = (level_q == FULL_LVL);
    empty = (level_q == '0);
    pop   = ~empty & out_ready;
    // A full FIFO still takes a capture when the head leaves in the same cycle.
    push  = in_valid & (~full | pop);
    drop  = in_valid & full & ~pop;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    csum_d   = csum_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      csum_d   = csum_q + in_wide;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end
    if (drop && (ovf_q != '1)) begin
      ovf_d = ovf_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= '0;
      csum_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      csum_q   <= csum_d;
    end
  end

  // Storage is not reset; contents behind the pointers are don't-care.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_small_q[wr_ptr_q] <= in_small;
      mem_quad_q[wr_ptr_q]  <= in_quad;
      mem_wide_q[wr_ptr_q]  <= in_wide;
    end
  end

  always_comb begin
    out_valid    = ~empty;
    out_small    = empty ? '0 : mem_small_q[rd_ptr_q];
    out_quad     = empty ? '0 : mem_quad_q[rd_ptr_q];
    out_wide     = empty ? '0 : mem_wide_q[rd_ptr_q];
    level        = level_q;
    overflow_cnt = ovf_q;
    checksum     = csum_q;
  end

endmodule

// File: tb/tb_result_capture_fifo.sv
module tb_result_capture_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [1:0]  in_small;
  logic [39:0] in_quad;
  logic [69:0] in_wide;
  logic        out_ready;

  logic        out_valid;
  logic [1:0]  out_small;
  logic [39:0] out_quad;
  logic [69:0] out_wide;
  logic [2:0]  level;
  logic [15:0] overflow_cnt;
  logic [69:0] checksum;

  logic        s_out_valid;
  logic [1:0]  s_out_small;
  logic [39:0] s_out_quad;
  logic [69:0] s_out_wide;
  logic [2:0]  s_level;
  logic [1:0]  s_overflow_cnt;
  logic [69:0] s_checksum;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  result_capture_fifo #(.DEPTH(4), .SMALL_W(2), .QUAD_W(40), .WIDE_W(70), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_small(in_small),
    .in_quad(in_quad), .in_wide(in_wide), .out_valid(out_valid),
    .out_ready(out_ready), .out_small(out_small), .out_quad(out_quad),
    .out_wide(out_wide), .level(level), .overflow_cnt(overflow_cnt),
    .checksum(checksum)
  );

  result_capture_fifo #(.DEPTH(4), .SMALL_W(2), .QUAD_W(40), .WIDE_W(70), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_small(in_small),
    .in_quad(in_quad), .in_wide(in_wide), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_small(s_out_small), .out_quad(s_out_quad),
    .out_wide(s_out_wide), .level(s_level), .overflow_cnt(s_overflow_cnt),
    .checksum(s_checksum)
  );

  typedef struct {
    logic        rst;
    logic        iv;
    logic [1:0]  s;
    logic [39:0] q;
    logic [69:0] w;
    logic        rdy;
    logic        ev;
    logic [1:0]  es;
    logic [39:0] eq;
    logic [69:0] ew;
    logic [2:0]  el;
    logic [15:0] eo;
    logic [69:0] ec;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(logic rst, logic iv, logic [1:0] s, logic [39:0] q,
                              logic [69:0] w, logic rdy, logic ev, logic [1:0] es,
                              logic [39:0] eq, logic [69:0] ew, logic [2:0] el,
                              logic [15:0] eo, logic [69:0] ec);
    vec_t v;
    v.rst = rst; v.iv = iv; v.s = s; v.q = q; v.w = w; v.rdy = rdy;
    v.ev = ev; v.es = es; v.eq = eq; v.ew = ew; v.el = el; v.eo = eo; v.ec = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are checked 1 ns after the rising edge.
  task automatic step(input logic rst, input logic iv, input logic [1:0] s,
                      input logic [39:0] q, input logic [69:0] w, input logic rdy);
    @(negedge clk);
    reset = rst; in_valid = iv; in_small = s; in_quad = q; in_wide = w; out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_small = '0; in_quad = '0; in_wide = '0; out_ready = 1'b0;

    //              rst iv  s  q       w        rdy  ev es eq      ew       el eo ec
    // Reset with in_valid high, then single capture and pop
    vecs[0]  = mk(1, 1, 2'd3, 40'h99, 70'h99,  0,   0, 0, 40'h0,  70'h0,   0, 0, 70'h0);
    vecs[1]  = mk(0, 1, 2'd3, 40'h1,  70'h5,   0,   1, 3, 40'h1,  70'h5,   1, 0, 70'h5);
    vecs[2]  = mk(0, 0, 2'd0, 40'h0,  70'h0,   1,   0, 0, 40'h0,  70'h0,   0, 0, 70'h5);
    // Five captures into four entries with the consumer stalled
    vecs[3]  = mk(0, 1, 2'd0, 40'h10, 70'h10,  0,   1, 0, 40'h10, 70'h10,  1, 0, 70'h15);
    vecs[4]  = mk(0, 1, 2'd1, 40'h20, 70'h20,  0,   1, 0, 40'h10, 70'h10,  2, 0, 70'h35);
    vecs[5]  = mk(0, 1, 2'd2, 40'h30, 70'h30,  0,   1, 0, 40'h10, 70'h10,  3, 0, 70'h65);
    vecs[6]  = mk(0, 1, 2'd3, 40'h40, 70'h40,  0,   1, 0, 40'h10, 70'h10,  4, 0, 70'hA5);
    vecs[7]  = mk(0, 1, 2'd0, 40'h50, 70'h50,  0,   1, 0, 40'h10, 70'h10,  4, 1, 70'hA5);
    // Full: simultaneous pop and push
    vecs[8]  = mk(0, 1, 2'd1, 40'h60, 70'h60,  1,   1, 1, 40'h20, 70'h20,  4, 1, 70'h105);
    // Drain, new triple comes out last
    vecs[9]  = mk(0, 0, 2'd0, 40'h0,  70'h0,   1,   1, 2, 40'h30, 70'h30,  3, 1, 70'h105);
    vecs[10] = mk(0, 0, 2'd0, 40'h0,  70'h0,   1,   1, 3, 40'h40, 70'h40,  2, 1, 70'h105);
    vecs[11] = mk(0, 0, 2'd0, 40'h0,  70'h0,   1,   1, 1, 40'h60, 70'h60,  1, 1, 70'h105);
    vecs[12] = mk(0, 0, 2'd0, 40'h0,  70'h0,   1,   0, 0, 40'h0,  70'h0,   0, 1, 70'h105);
    // Build level=3, overflow=2, then reset mid-operation
    vecs[13] = mk(0, 1, 2'd0, 40'h70, 70'h1,   0,   1, 0, 40'h70, 70'h1,   1, 1, 70'h106);
    vecs[14] = mk(0, 1, 2'd1, 40'h71, 70'h2,   0,   1, 0, 40'h70, 70'h1,   2, 1, 70'h108);
    vecs[15] = mk(0, 1, 2'd2, 40'h72, 70'h3,   0,   1, 0, 40'h70, 70'h1,   3, 1, 70'h10B);
    vecs[16] = mk(0, 1, 2'd3, 40'h73, 70'h4,   0,   1, 0, 40'h70, 70'h1,   4, 1, 70'h10F);
    vecs[17] = mk(0, 1, 2'd0, 40'h74, 70'h5,   0,   1, 0, 40'h70, 70'h1,   4, 2, 70'h10F);
    vecs[18] = mk(0, 0, 2'd0, 40'h0,  70'h0,   1,   1, 1, 40'h71, 70'h2,   3, 2, 70'h10F);
    vecs[19] = mk(1, 1, 2'd3, 40'hFF, 70'hFF,  1,   0, 0, 40'h0,  70'h0,   0, 0, 70'h0);
    vecs[20] = mk(0, 0, 2'd0, 40'h0,  70'h0,   0,   0, 0, 40'h0,  70'h0,   0, 0, 70'h0);

    for (int i = 0; i < 21; i++) begin
      step(vecs[i].rst, vecs[i].iv, vecs[i].s, vecs[i].q, vecs[i].w, vecs[i].rdy);
      chk($sformatf("v%0d_valid", i), 70'(out_valid),    70'(vecs[i].ev));
      chk($sformatf("v%0d_small", i), 70'(out_small),    70'(vecs[i].es));
      chk($sformatf("v%0d_quad", i),  70'(out_quad),     70'(vecs[i].eq));
      chk($sformatf("v%0d_wide", i),  out_wide,          vecs[i].ew);
      chk($sformatf("v%0d_level", i), 70'(level),        70'(vecs[i].el));
      chk($sformatf("v%0d_ovf", i),   70'(overflow_cnt), 70'(vecs[i].eo));
      chk($sformatf("v%0d_csum", i),  checksum,          vecs[i].ec);
    end

    // Streaming: ten back-to-back captures with the consumer always ready
    begin
      logic [69:0] sum;
      int pops;
      sum = '0;
      pops = 0;
      step(1, 0, 2'd0, 40'h0, 70'h0, 1);
      for (int k = 0; k < 10; k++) begin
        step(0, 1, 2'(k), 40'(200 + k), 70'(100 + k), 1);
        sum = sum + 70'(100 + k);
        if (out_valid === 1'b1) pops++;
        chk($sformatf("stream%0d_valid", k), 70'(out_valid), 70'd1);
        chk($sformatf("stream%0d_small", k), 70'(out_small), 70'(k % 4));
        chk($sformatf("stream%0d_quad", k),  70'(out_quad),  70'(200 + k));
        chk($sformatf("stream%0d_wide", k),  out_wide,       70'(100 + k));
        chk($sformatf("stream%0d_level", k), 70'(level),     70'd1);
      end
      step(0, 0, 2'd0, 40'h0, 70'h0, 1);
      chk("stream_pops",      70'(pops),      70'd10);
      chk("stream_end_valid", 70'(out_valid), 70'd0);
      chk("stream_end_level", 70'(level),     70'd0);
      chk("stream_csum",      checksum,       sum);
    end

    // Checksum wrap and 2-bit overflow saturation
    begin
      logic [69:0] ones;
      logic [69:0] exp_wrap;
      ones = '1;
      exp_wrap = 70'h3F_FFFF_FFFF_FFFF_FFFE;
      step(1, 0, 2'd0, 40'h0, 70'h0, 0);
      step(0, 1, 2'd1, 40'h1, ones, 0);
      step(0, 1, 2'd2, 40'h2, ones, 0);
      chk("wrap_csum",     checksum,   exp_wrap);
      chk("wrap_csum_sat", s_checksum, exp_wrap);
      step(0, 1, 2'd3, 40'h3, 70'h0, 0);
      step(0, 1, 2'd0, 40'h4, 70'h0, 0);
      chk("sat_full_level", 70'(s_level), 70'd4);
      for (int d = 1; d <= 5; d++) begin
        step(0, 1, 2'd1, 40'(d), 70'(d), 0);
        chk($sformatf("sat_drop%0d", d), 70'(s_overflow_cnt), 70'((d > 3) ? 3 : d));
        chk($sformatf("ovf16_drop%0d", d), 70'(overflow_cnt), 70'(d));
      end
      chk("sat_csum_unchanged", s_checksum, exp_wrap);
      chk("sat_head_small",     70'(s_out_small), 70'd1);
      chk("sat_head_wide",      s_out_wide, ones);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
